// File: rtl/pipe_pkg.sv
// Shared opcodes, controller state encoding and forwarding select codes
// for the pipeline hazard controller.
package pipe_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LW   = 4'h8;
  localparam logic [3:0] OP_SW   = 4'h9;
  localparam logic [3:0] OP_BR   = 4'hC;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    MEM_WAIT = 2'd2,
    HALTED   = 2'd3
  } ctrl_state_t;

  typedef logic [1:0] fwd_sel_t;

  localparam fwd_sel_t FWD_RF    = 2'b00;
  localparam fwd_sel_t FWD_EXMEM = 2'b01;
  localparam fwd_sel_t FWD_MEMWB = 2'b10;

  function automatic logic is_mem_op(input logic [3:0] opcode);
    return (opcode == OP_LW) || (opcode == OP_SW);
  endfunction

endpackage

// File: rtl/fwd_unit.sv
// Combinational operand-forwarding compare for both EX operands; the
// younger EX_MEM result wins over MEM_WB, and r0 never forwards.
module fwd_unit
  import pipe_pkg::*;
(
  input  logic [2:0] ex_reg1,
  input  logic [2:0] ex_reg2,
  input  logic       mem_writeReg,
  input  logic [2:0] mem_regD,
  input  logic       wb_writeReg,
  input  logic [2:0] wb_regD,
  output fwd_sel_t   fwd_a,
  output fwd_sel_t   fwd_b
);

  function automatic fwd_sel_t pick(input logic [2:0] src);
    if (mem_writeReg && (mem_regD == src) && (mem_regD != 3'd0)) return FWD_EXMEM;
    if (wb_writeReg && (wb_regD == src) && (wb_regD != 3'd0))    return FWD_MEMWB;
    return FWD_RF;
  endfunction

  assign fwd_a = pick(ex_reg1);
  assign fwd_b = pick(ex_reg2);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline controller: register enables/flushes, operand forwarding, and
// sequencing of load-use stalls, memory wait states, branch flushes and HALT.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       id_opcode,
  input  logic [2:0]       id_reg1,
  input  logic [2:0]       id_reg2,
  input  logic [3:0]       ex_opcode,
  input  logic [2:0]       ex_regD,
  input  logic [2:0]       ex_reg1,
  input  logic [2:0]       ex_reg2,
  input  logic             ex_branch_taken,
  input  logic             mem_writeReg,
  input  logic [2:0]       mem_regD,
  input  logic [3:0]       mem_opcode,
  input  logic             mem_ready,
  input  logic             wb_writeReg,
  input  logic [2:0]       wb_regD,
  output logic             en_pc,
  output logic             en_if_id,
  output logic             en_id_ex,
  output logic             en_ex_mem,
  output logic             en_mem_wb,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic             flush_ex_mem,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             halted,
  output logic             mem_abort,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

  ctrl_state_t      state_q, state_d;
  logic [7:0]       wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             halted_q, halted_d;
  logic             mem_abort_q, mem_abort_d;

  logic [4:0] en_v;
  logic [2:0] flush_v;
  logic       mem_busy;
  logic       load_use;
  fwd_sel_t   fwd_a_w, fwd_b_w;
  logic       id_unused;

  // The ID opcode is not needed: a matching source field stalls regardless.
  assign id_unused = ^id_opcode;

  assign mem_busy = is_mem_op(mem_opcode) && !mem_ready;
  assign load_use = (ex_opcode == OP_LW) && (ex_regD != 3'd0) &&
                    ((ex_regD == id_reg1) || (ex_regD == id_reg2));

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    stall_cnt_d = stall_cnt_q;
    halted_d    = halted_q;
    mem_abort_d = 1'b0;
    en_v        = 5'b11111;
    flush_v     = 3'b000;
    if (state_q == HALTED) begin
      en_v = 5'b00011;
    end else if (mem_busy) begin
      // Timeout squashes the stuck access so the pipeline can move on.
      en_v = 5'b00000;
      if (wait_cnt_q == TMO_LAST) begin
        flush_v     = 3'b001;
        state_d     = RUN;
        wait_cnt_d  = 8'd0;
        mem_abort_d = 1'b1;
      end else begin
        state_d    = MEM_WAIT;
        wait_cnt_d = wait_cnt_q + 8'd1;
      end
    end else begin
      state_d    = RUN;
      wait_cnt_d = 8'd0;
      if (state_q == RUN) begin
        if (ex_branch_taken) begin
          flush_v = 3'b110;
        end else if (load_use) begin
          en_v    = 5'b00111;
          flush_v = 3'b010;
          state_d = LU_STALL;
        end
      end
      if (mem_opcode == OP_HALT) begin
        state_d  = HALTED;
        halted_d = 1'b1;
      end
    end
    if (!en_v[4] && (state_q != HALTED) && !(&stall_cnt_q))
      stall_cnt_d = stall_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RUN;
      wait_cnt_q  <= 8'd0;
      stall_cnt_q <= '0;
      halted_q    <= 1'b0;
      mem_abort_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      halted_q    <= halted_d;
      mem_abort_q <= mem_abort_d;
    end
  end

  fwd_unit u_fwd (
    .ex_reg1      (ex_reg1),
    .ex_reg2      (ex_reg2),
    .mem_writeReg (mem_writeReg),
    .mem_regD     (mem_regD),
    .wb_writeReg  (wb_writeReg),
    .wb_regD      (wb_regD),
    .fwd_a        (fwd_a_w),
    .fwd_b        (fwd_b_w)
  );

  // Reset freezes every register and fills the pipeline with bubbles.
  assign {en_pc, en_if_id, en_id_ex, en_ex_mem, en_mem_wb} = rst ? 5'b00000 : en_v;
  assign {flush_if_id, flush_id_ex, flush_ex_mem}          = rst ? 3'b111 : flush_v;
  assign fwd_a     = rst ? FWD_RF : fwd_a_w;
  assign fwd_b     = rst ? FWD_RF : fwd_b_w;
  assign halted    = halted_q;
  assign mem_abort = mem_abort_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: the driver queues hand-computed
// expectations per cycle, a negedge monitor pops and compares them.
module tb_pipe_hazard_ctrl;

  localparam logic [3:0] NOP = 4'h0, LW = 4'h8, SW = 4'h9, HALT = 4'hF;

  logic       clk, rst;
  logic [3:0] id_opcode, ex_opcode, mem_opcode;
  logic [2:0] id_reg1, id_reg2, ex_regD, ex_reg1, ex_reg2, mem_regD, wb_regD;
  logic       ex_branch_taken, mem_writeReg, mem_ready, wb_writeReg;
  logic       en_pc, en_if_id, en_id_ex, en_ex_mem, en_mem_wb;
  logic       flush_if_id, flush_id_ex, flush_ex_mem;
  logic [1:0] fwd_a, fwd_b;
  logic       halted, mem_abort;
  logic [7:0] stall_cnt;

  pipe_hazard_ctrl #(.MEM_TIMEOUT(15), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .id_opcode(id_opcode), .id_reg1(id_reg1), .id_reg2(id_reg2),
    .ex_opcode(ex_opcode), .ex_regD(ex_regD), .ex_reg1(ex_reg1), .ex_reg2(ex_reg2),
    .ex_branch_taken(ex_branch_taken),
    .mem_writeReg(mem_writeReg), .mem_regD(mem_regD), .mem_opcode(mem_opcode),
    .mem_ready(mem_ready), .wb_writeReg(wb_writeReg), .wb_regD(wb_regD),
    .en_pc(en_pc), .en_if_id(en_if_id), .en_id_ex(en_id_ex),
    .en_ex_mem(en_ex_mem), .en_mem_wb(en_mem_wb),
    .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex), .flush_ex_mem(flush_ex_mem),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .halted(halted), .mem_abort(mem_abort),
    .stall_cnt(stall_cnt)
  );

  typedef struct {
    string      name;
    logic [4:0] en;
    logic [2:0] fl;
    logic [1:0] fa;
    logic [1:0] fb;
    logic       hl;
    logic       ab;
    logic [7:0] sc;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  int   checks = 0;
  int   errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string n, input string f, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s.%s: got %0h, expected %0h (t=%0t)", n, f, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      cur = exp_q.pop_front();
      chk(cur.name, "en", {3'b0, en_pc, en_if_id, en_id_ex, en_ex_mem, en_mem_wb}, {3'b0, cur.en});
      chk(cur.name, "flush", {5'b0, flush_if_id, flush_id_ex, flush_ex_mem}, {5'b0, cur.fl});
      chk(cur.name, "fwd_a", {6'b0, fwd_a}, {6'b0, cur.fa});
      chk(cur.name, "fwd_b", {6'b0, fwd_b}, {6'b0, cur.fb});
      chk(cur.name, "halted", {7'b0, halted}, {7'b0, cur.hl});
      chk(cur.name, "mem_abort", {7'b0, mem_abort}, {7'b0, cur.ab});
      chk(cur.name, "stall_cnt", stall_cnt, cur.sc);
    end
  end

  task automatic cyc(input string name, input logic [4:0] en, input logic [2:0] fl,
                     input logic [1:0] fa, input logic [1:0] fb, input logic hl,
                     input logic ab, input logic [7:0] sc);
    exp_t e;
    e.name = name; e.en = en; e.fl = fl; e.fa = fa; e.fb = fb;
    e.hl = hl; e.ab = ab; e.sc = sc;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_opcode = NOP; id_reg1 = 3'd0; id_reg2 = 3'd0;
    ex_opcode = NOP; ex_regD = 3'd0; ex_reg1 = 3'd0; ex_reg2 = 3'd0;
    ex_branch_taken = 1'b0;
    mem_writeReg = 1'b0; mem_regD = 3'd0; mem_opcode = NOP; mem_ready = 1'b1;
    wb_writeReg = 1'b0; wb_regD = 3'd0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    idle();
    mem_writeReg = 1'b1; mem_regD = 3'd5; ex_reg1 = 3'd5;
    @(posedge clk); #1;
    cyc("reset", 5'b00000, 3'b111, 2'b00, 2'b00, 1'b0, 1'b0, 8'd0);
    rst = 1'b0;
    idle();
    cyc("idle", 5'b11111, 3'b000, 2'b00, 2'b00, 1'b0, 1'b0, 8'd0);

    // load-use on id_reg2, then the r0 exclusion
    ex_opcode = LW; ex_regD = 3'd3; id_reg2 = 3'd3;
    cyc("lu_stall", 5'b00111, 3'b010, 2'b00, 2'b00, 1'b0, 1'b0, 8'd0);
    cyc("lu_release", 5'b11111, 3'b000, 2'b00, 2'b00, 1'b0, 1'b0, 8'd1);
    ex_regD = 3'd0; id_reg1 = 3'd0; id_reg2 = 3'd0;
    cyc("lu_r0", 5'b11111, 3'b000, 2'b00, 2'b00, 1'b0, 1'b0, 8'd1);

    // three memory wait states then completion
    idle();
    mem_opcode = LW; mem_ready = 1'b0;
    cyc("mw1", 5'b00000, 3'b000, 2'b00, 2'b00, 1'b0, 1'b0, 8'd1);
    cyc("mw2", 5'b00000, 3'b000, 2'b00, 2'b00, 1'b0, 1'b0, 8'd2);
    cyc("mw3", 5'b00000, 3'b000, 2'b00, 2'b00, 1'b0, 1'b0, 8'd3);
    mem_ready = 1'b1;
    cyc("mw_done", 5'b11111, 3'b000, 2'b00, 2'b00, 1'b0, 1'b0, 8'd4);
    idle();
    cyc("mw_after", 5'b11111, 3'b000, 2'b00, 2'b00, 1'b0, 1'b0, 8'd4);

    // memory timeout after 15 wait cycles
    mem_opcode = SW; mem_ready = 1'b0;
    for (int k = 1; k <= 14; k++)
      cyc("tmo_wait", 5'b00000, 3'b000, 2'b00, 2'b00, 1'b0, 1'b0, 8'(3 + k));
    cyc("tmo_flush", 5'b00000, 3'b001, 2'b00, 2'b00, 1'b0, 1'b0, 8'd18);
    idle();
    cyc("abort_pulse", 5'b11111, 3'b000, 2'b00, 2'b00, 1'b0, 1'b1, 8'd19);
    cyc("abort_clear", 5'b11111, 3'b000, 2'b00, 2'b00, 1'b0, 1'b0, 8'd19);

    // taken branch cancels a coincident load-use stall
    ex_opcode = LW; ex_regD = 3'd2; id_reg1 = 3'd2; ex_branch_taken = 1'b1;
    cyc("br_lu", 5'b11111, 3'b110, 2'b00, 2'b00, 1'b0, 1'b0, 8'd19);
    ex_branch_taken = 1'b0;
    cyc("br_no_lu", 5'b00111, 3'b010, 2'b00, 2'b00, 1'b0, 1'b0, 8'd19);
    cyc("br_lu_rel", 5'b11111, 3'b000, 2'b00, 2'b00, 1'b0, 1'b0, 8'd20);

    // forwarding priority and r0
    idle();
    ex_reg1 = 3'd5; mem_regD = 3'd5; wb_regD = 3'd5; mem_writeReg = 1'b1; wb_writeReg = 1'b1;
    cyc("fwd_exmem", 5'b11111, 3'b000, 2'b01, 2'b00, 1'b0, 1'b0, 8'd20);
    mem_writeReg = 1'b0;
    cyc("fwd_memwb", 5'b11111, 3'b000, 2'b10, 2'b00, 1'b0, 1'b0, 8'd20);
    ex_reg1 = 3'd0;
    cyc("fwd_r0_a", 5'b11111, 3'b000, 2'b00, 2'b00, 1'b0, 1'b0, 8'd20);
    ex_reg2 = 3'd5;
    cyc("fwd_b_memwb", 5'b11111, 3'b000, 2'b00, 2'b10, 1'b0, 1'b0, 8'd20);
    mem_writeReg = 1'b1;
    cyc("fwd_b_exmem", 5'b11111, 3'b000, 2'b00, 2'b01, 1'b0, 1'b0, 8'd20);
    mem_regD = 3'd0; wb_regD = 3'd0; ex_reg2 = 3'd0;
    cyc("fwd_b_r0", 5'b11111, 3'b000, 2'b00, 2'b00, 1'b0, 1'b0, 8'd20);
    mem_regD = 3'd6; wb_regD = 3'd4; ex_reg1 = 3'd4; ex_reg2 = 3'd6;
    cyc("fwd_mixed", 5'b11111, 3'b000, 2'b10, 2'b01, 1'b0, 1'b0, 8'd20);

    // HALT drains older stages and ignores every other event
    idle();
    mem_opcode = HALT;
    cyc("halt_enter", 5'b11111, 3'b000, 2'b00, 2'b00, 1'b0, 1'b0, 8'd20);
    mem_opcode = LW; mem_ready = 1'b0; ex_branch_taken = 1'b1;
    ex_opcode = LW; ex_regD = 3'd1; id_reg1 = 3'd1;
    for (int k = 0; k < 300; k++)
      cyc("halted", 5'b00011, 3'b000, 2'b00, 2'b00, 1'b1, 1'b0, 8'd20);
    rst = 1'b1;
    cyc("halt_rst", 5'b00000, 3'b111, 2'b00, 2'b00, 1'b0, 1'b0, 8'd0);
    rst = 1'b0;
    idle();
    cyc("rst_idle", 5'b11111, 3'b000, 2'b00, 2'b00, 1'b0, 1'b0, 8'd0);

    // reset in the middle of a wait must clear the wait counter
    mem_opcode = LW; mem_ready = 1'b0;
    for (int k = 1; k <= 5; k++)
      cyc("rst_mw", 5'b00000, 3'b000, 2'b00, 2'b00, 1'b0, 1'b0, 8'(k - 1));
    rst = 1'b1;
    cyc("rst_midwait", 5'b00000, 3'b111, 2'b00, 2'b00, 1'b0, 1'b0, 8'd0);
    rst = 1'b0;

    // continuous busy memory: repeated timeouts, counter saturates at 255
    for (int k = 1; k <= 300; k++)
      cyc("sat", 5'b00000, (k % 15 == 0) ? 3'b001 : 3'b000, 2'b00, 2'b00, 1'b0,
          (k > 1) && (k % 15 == 1), (k > 256) ? 8'd255 : 8'(k - 1));
    idle();
    cyc("sat_hold", 5'b11111, 3'b000, 2'b00, 2'b00, 1'b0, 1'b1, 8'd255);
    cyc("sat_end", 5'b11111, 3'b000, 2'b00, 2'b00, 1'b0, 1'b0, 8'd255);

    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
